// File: rtl/la_jtag_pkg.sv
// rtl/la_jtag_pkg.sv - TAP state encodings, instruction codes and next-state function
package la_jtag_pkg;

    // IEEE 1149.1 reference state encoding, visible on the tap_state port.
    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SELECT_IR  = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SELECT_DR  = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RUN_IDLE   = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TEST_RESET = 4'hF
    } tap_state_e;

    localparam int IR_IDCODE = 1;
    localparam int IR_USER0  = 2;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TEST_RESET: return tms ? TEST_RESET : RUN_IDLE;
            RUN_IDLE:   return tms ? SELECT_DR  : RUN_IDLE;
            SELECT_DR:  return tms ? SELECT_IR  : CAPTURE_DR;
            CAPTURE_DR: return tms ? EXIT1_DR   : SHIFT_DR;
            SHIFT_DR:   return tms ? EXIT1_DR   : SHIFT_DR;
            EXIT1_DR:   return tms ? UPDATE_DR  : PAUSE_DR;
            PAUSE_DR:   return tms ? EXIT2_DR   : PAUSE_DR;
            EXIT2_DR:   return tms ? UPDATE_DR  : SHIFT_DR;
            UPDATE_DR:  return tms ? SELECT_DR  : RUN_IDLE;
            SELECT_IR:  return tms ? TEST_RESET : CAPTURE_IR;
            CAPTURE_IR: return tms ? EXIT1_IR   : SHIFT_IR;
            SHIFT_IR:   return tms ? EXIT1_IR   : SHIFT_IR;
            EXIT1_IR:   return tms ? UPDATE_IR  : PAUSE_IR;
            PAUSE_IR:   return tms ? EXIT2_IR   : PAUSE_IR;
            EXIT2_IR:   return tms ? UPDATE_IR  : SHIFT_IR;
            UPDATE_IR:  return tms ? SELECT_DR  : RUN_IDLE;
            default:    return TEST_RESET;
        endcase
    endfunction

endpackage

// File: rtl/la_jtag_tapfsm.sv
// rtl/la_jtag_tapfsm.sv - JTAG pin synchroniser, TCK edge detect and 16-state TAP FSM
// Ports: clk/reset core clock and sync reset; tck/tms/tdi/trst_n raw pad inputs;
// tap_state/tap_state_next current and rise-successor state; tck_rise/tck_fall
// one-clk edge strobes; tdi_sync aligned TDI; tap_reset = reset or synced TRST low.
module la_jtag_tapfsm #(
    parameter int SYNC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tck_in,
    input  logic       tms_in,
    input  logic       tdi_in,
    input  logic       trst_n_in,
    output logic [3:0] tap_state,
    output logic [3:0] tap_state_next,
    output logic       tck_rise,
    output logic       tck_fall,
    output logic       tdi_sync,
    output logic       tap_reset
);
    import la_jtag_pkg::*;

    logic [SYNC-1:0] tck_sync_q, tck_sync_d;
    logic [SYNC-1:0] tms_sync_q, tms_sync_d;
    logic [SYNC-1:0] tdi_sync_q, tdi_sync_d;
    logic [SYNC-1:0] trst_sync_q, trst_sync_d;
    logic            tck_hist_q, tck_hist_d;
    tap_state_e      state_q, state_d, state_nx;

    // All four pins share one chain depth so TMS/TDI stay aligned with TCK.
    always_comb begin
        tck_sync_d  = {tck_sync_q[SYNC-2:0], tck_in};
        tms_sync_d  = {tms_sync_q[SYNC-2:0], tms_in};
        tdi_sync_d  = {tdi_sync_q[SYNC-2:0], tdi_in};
        trst_sync_d = {trst_sync_q[SYNC-2:0], trst_n_in};
        tck_hist_d  = tck_sync_q[SYNC-1];
    end

    assign tck_rise  = tck_sync_q[SYNC-1] & ~tck_hist_q;
    assign tck_fall  = ~tck_sync_q[SYNC-1] & tck_hist_q;
    assign tdi_sync  = tdi_sync_q[SYNC-1];
    // The synchroniser itself must keep running while TRST is low.
    assign tap_reset = reset | ~trst_sync_q[SYNC-1];

    assign state_nx = tap_next(state_q, tms_sync_q[SYNC-1]);

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            state_d = state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
            trst_sync_q <= '0;
            tck_hist_q  <= 1'b0;
        end else begin
            tck_sync_q  <= tck_sync_d;
            tms_sync_q  <= tms_sync_d;
            tdi_sync_q  <= tdi_sync_d;
            trst_sync_q <= trst_sync_d;
            tck_hist_q  <= tck_hist_d;
        end
        if (tap_reset) begin
            state_q <= TEST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign tap_state      = state_q;
    assign tap_state_next = state_nx;

endmodule

// File: rtl/la_jtag_tap.sv
// rtl/la_jtag_tap.sv - JTAG TAP with IR, BYPASS, IDCODE and user data registers
// Ports: clk/reset core clock and sync reset; jtag_* pad-side TCK/TMS/TRST/TDI in,
// TDO and its enable out; dr_capture_data NDR slices captured into USERi;
// dr_update_data/dr_update_valid update-side data and per-USER one-clk strobe;
// ir_value current instruction; tap_state current FSM state.
module la_jtag_tap #(
    parameter int          IRW    = 5,
    parameter int          NDR    = 2,
    parameter int          DRW    = 32,
    parameter logic [31:0] IDCODE = 32'h1000_0001,
    parameter int          SYNC   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               jtag_tck_in,
    input  logic               jtag_tms_in,
    input  logic               jtag_trst_in,
    input  logic               jtag_tdi_in,
    output logic               jtag_tdo_out,
    output logic               jtag_tdo_oe,
    input  logic [NDR*DRW-1:0] dr_capture_data,
    output logic [DRW-1:0]     dr_update_data,
    output logic [NDR-1:0]     dr_update_valid,
    output logic [IRW-1:0]     ir_value,
    output logic [3:0]         tap_state
);
    import la_jtag_pkg::*;

    logic [3:0] fsm_state, fsm_state_next;
    logic       tck_rise, tck_fall, tdi_s, tap_reset;
    tap_state_e st, st_next;

    la_jtag_tapfsm #(.SYNC(SYNC)) u_tapfsm (
        .clk            (clk),
        .reset          (reset),
        .tck_in         (jtag_tck_in),
        .tms_in         (jtag_tms_in),
        .tdi_in         (jtag_tdi_in),
        .trst_n_in      (jtag_trst_in),
        .tap_state      (fsm_state),
        .tap_state_next (fsm_state_next),
        .tck_rise       (tck_rise),
        .tck_fall       (tck_fall),
        .tdi_sync       (tdi_s),
        .tap_reset      (tap_reset)
    );

    assign st      = tap_state_e'(fsm_state);
    assign st_next = tap_state_e'(fsm_state_next);

    logic [IRW-1:0] ir_sr_q, ir_sr_d;
    logic [IRW-1:0] ir_q, ir_d;
    logic [31:0]    idc_sr_q, idc_sr_d;
    logic           byp_sr_q, byp_sr_d;
    logic [DRW-1:0] usr_sr_q, usr_sr_d;
    logic [DRW-1:0] upd_data_q, upd_data_d;
    logic [NDR-1:0] upd_valid_q, upd_valid_d;
    logic           tdo_q, tdo_d;
    logic           oe_q, oe_d;

    logic           sel_idcode;
    logic           user_hit;
    logic [NDR-1:0] user_onehot;
    logic [DRW-1:0] user_cap;
    logic           dr_bit0;

    // Anything that is neither IDCODE nor a USER code falls through to BYPASS.
    always_comb begin
        sel_idcode  = (ir_q == IRW'(IR_IDCODE));
        user_hit    = 1'b0;
        user_onehot = '0;
        user_cap    = '0;
        for (int i = 0; i < NDR; i++) begin
            if (ir_q == IRW'(IR_USER0 + i)) begin
                user_hit       = 1'b1;
                user_onehot[i] = 1'b1;
                user_cap       = dr_capture_data[i*DRW +: DRW];
            end
        end
        dr_bit0 = sel_idcode ? idc_sr_q[0] : (user_hit ? usr_sr_q[0] : byp_sr_q);
    end

    always_comb begin
        ir_sr_d     = ir_sr_q;
        ir_d        = ir_q;
        idc_sr_d    = idc_sr_q;
        byp_sr_d    = byp_sr_q;
        usr_sr_d    = usr_sr_q;
        upd_data_d  = upd_data_q;
        upd_valid_d = '0;
        tdo_d       = tdo_q;
        oe_d        = oe_q;

        if (tck_rise) begin
            // Capture and shift act on the edge that leaves the state.
            case (st)
                CAPTURE_IR: ir_sr_d = IRW'(1);
                SHIFT_IR:   ir_sr_d = {tdi_s, ir_sr_q[IRW-1:1]};
                CAPTURE_DR: begin
                    if (sel_idcode) begin
                        idc_sr_d = IDCODE;
                    end else if (user_hit) begin
                        usr_sr_d = user_cap;
                    end else begin
                        byp_sr_d = 1'b0;
                    end
                end
                SHIFT_DR: begin
                    if (sel_idcode) begin
                        idc_sr_d = {tdi_s, idc_sr_q[31:1]};
                    end else if (user_hit) begin
                        // Concatenate-then-shift also covers DRW == 1.
                        usr_sr_d = DRW'({tdi_s, usr_sr_q} >> 1);
                    end else begin
                        byp_sr_d = tdi_s;
                    end
                end
                default: ;
            endcase

            // Update acts on the edge that enters the state.
            if (st_next == UPDATE_IR) begin
                ir_d = ir_sr_q;
            end
            if (st_next == UPDATE_DR && user_hit) begin
                upd_data_d  = usr_sr_q;
                upd_valid_d = user_onehot;
            end
        end

        if (tck_fall) begin
            tdo_d = (st == SHIFT_IR) ? ir_sr_q[0] : dr_bit0;
            oe_d  = (st == SHIFT_IR) || (st == SHIFT_DR);
        end

        if (st == TEST_RESET) begin
            ir_d = IRW'(IR_IDCODE);
        end
    end

    always_ff @(posedge clk) begin
        if (tap_reset) begin
            ir_sr_q     <= '0;
            ir_q        <= IRW'(IR_IDCODE);
            idc_sr_q    <= '0;
            byp_sr_q    <= 1'b0;
            usr_sr_q    <= '0;
            upd_data_q  <= '0;
            upd_valid_q <= '0;
            tdo_q       <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            ir_sr_q     <= ir_sr_d;
            ir_q        <= ir_d;
            idc_sr_q    <= idc_sr_d;
            byp_sr_q    <= byp_sr_d;
            usr_sr_q    <= usr_sr_d;
            upd_data_q  <= upd_data_d;
            upd_valid_q <= upd_valid_d;
            tdo_q       <= tdo_d;
            oe_q        <= oe_d;
        end
    end

    assign jtag_tdo_out    = tdo_q;
    assign jtag_tdo_oe     = oe_q;
    assign dr_update_data  = upd_data_q;
    assign dr_update_valid = upd_valid_q;
    assign ir_value        = ir_q;
    assign tap_state       = fsm_state;

endmodule

// File: tb/tb_la_jtag_tap.sv
// tb/tb_la_jtag_tap.sv - directed table-driven bench for la_jtag_tap
module tb_la_jtag_tap;
    localparam int IRW  = 5;
    localparam int NDR  = 2;
    localparam int DRW  = 32;
    localparam int SYNC = 2;
    localparam int HALF = 5;

    logic clk = 1'b0;
    logic reset, tck, tms, trst_n, tdi;
    logic jtag_tdo_out, jtag_tdo_oe;
    logic [NDR*DRW-1:0] cap_data;
    logic [DRW-1:0] upd_data;
    logic [NDR-1:0] upd_valid;
    logic [IRW-1:0] ir_value;
    logic [3:0] tap_state;

    la_jtag_tap #(.IRW(IRW), .NDR(NDR), .DRW(DRW), .IDCODE(32'h1000_0001), .SYNC(SYNC)) dut (
        .clk             (clk),
        .reset           (reset),
        .jtag_tck_in     (tck),
        .jtag_tms_in     (tms),
        .jtag_trst_in    (trst_n),
        .jtag_tdi_in     (tdi),
        .jtag_tdo_out    (jtag_tdo_out),
        .jtag_tdo_oe     (jtag_tdo_oe),
        .dr_capture_data (cap_data),
        .dr_update_data  (upd_data),
        .dr_update_valid (upd_valid),
        .ir_value        (ir_value),
        .tap_state       (tap_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    logic [NDR-1:0] pulse_last = '0;

    always @(negedge clk) begin
        if (upd_valid !== '0) begin
            pulse_cnt++;
            pulse_last = upd_valid;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic m, input logic d);
        tms = m;
        tdi = d;
        tck = 1'b1;
        clks(HALF);
        tck = 1'b0;
        clks(HALF);
    endtask

    // Starts and ends in Run-Test/Idle; TDO is read before each shifting rise.
    task automatic scan(input logic is_ir, input int n, input logic [31:0] din,
                        output logic [31:0] dout, output int oe_bad);
        dout = '0;
        oe_bad = 0;
        tick(1'b1, 1'b0);
        if (is_ir) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = jtag_tdo_out;
            if (jtag_tdo_oe !== 1'b1) oe_bad++;
            tick(i == n - 1, din[i]);
        end
        if (jtag_tdo_oe !== 1'b0) oe_bad++;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    typedef struct {
        logic           is_ir;
        int             n;
        logic [31:0]    din;
        logic [31:0]    exp_dout;
        logic [IRW-1:0] exp_ir;
        logic [NDR-1:0] exp_pulse;
        logic [31:0]    exp_upd;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] dout;
        int oe_bad;
        int p0;

        vecs[0]  = '{1'b0, 32, 32'h0000_0000, 32'h1000_0001, 5'h01, 2'b00, 32'h0000_0000};
        vecs[1]  = '{1'b1,  5, 32'h0000_001F, 32'h0000_0001, 5'h1F, 2'b00, 32'h0000_0000};
        vecs[2]  = '{1'b0,  4, 32'h0000_000D, 32'h0000_000A, 5'h1F, 2'b00, 32'h0000_0000};
        vecs[3]  = '{1'b1,  5, 32'h0000_0002, 32'h0000_0001, 5'h02, 2'b00, 32'h0000_0000};
        vecs[4]  = '{1'b0, 32, 32'h1234_5678, 32'hDEAD_BEEF, 5'h02, 2'b01, 32'h1234_5678};
        vecs[5]  = '{1'b1,  5, 32'h0000_0003, 32'h0000_0001, 5'h03, 2'b00, 32'h1234_5678};
        vecs[6]  = '{1'b0, 32, 32'hA5A5_0F0F, 32'h0BAD_F00D, 5'h03, 2'b10, 32'hA5A5_0F0F};
        vecs[7]  = '{1'b1,  5, 32'h0000_0004, 32'h0000_0001, 5'h04, 2'b00, 32'hA5A5_0F0F};
        vecs[8]  = '{1'b0,  3, 32'h0000_0003, 32'h0000_0006, 5'h04, 2'b00, 32'hA5A5_0F0F};
        vecs[9]  = '{1'b1,  5, 32'h0000_0001, 32'h0000_0001, 5'h01, 2'b00, 32'hA5A5_0F0F};
        vecs[10] = '{1'b0, 32, 32'hFFFF_FFFF, 32'h1000_0001, 5'h01, 2'b00, 32'hA5A5_0F0F};

        reset = 1'b1;
        tck = 1'b0;
        tms = 1'b1;
        tdi = 1'b0;
        trst_n = 1'b1;
        cap_data = {32'h0BAD_F00D, 32'hDEAD_BEEF};
        clks(5);
        check("rst_state", tap_state, 4'hF);
        check("rst_ir", ir_value, 5'h01);
        check("rst_tdo", jtag_tdo_out, 1'b0);
        check("rst_oe", jtag_tdo_oe, 1'b0);
        check("rst_valid", upd_valid, 2'b00);
        check("rst_data", upd_data, 32'h0);
        reset = 1'b0;
        clks(4);
        tick(1'b0, 1'b0);

        for (int i = 0; i < 11; i++) begin
            p0 = pulse_cnt;
            scan(vecs[i].is_ir, vecs[i].n, vecs[i].din, dout, oe_bad);
            check($sformatf("v%0d_tdo", i), dout, vecs[i].exp_dout);
            check($sformatf("v%0d_oe", i), oe_bad, 0);
            check($sformatf("v%0d_ir", i), ir_value, vecs[i].exp_ir);
            check($sformatf("v%0d_state", i), tap_state, 4'hC);
            check($sformatf("v%0d_npulse", i), pulse_cnt - p0, (vecs[i].exp_pulse != '0) ? 1 : 0);
            if (vecs[i].exp_pulse != '0)
                check($sformatf("v%0d_pulse", i), pulse_last, vecs[i].exp_pulse);
            check($sformatf("v%0d_upd", i), upd_data, vecs[i].exp_upd);
        end

        // Five TMS=1 rises from mid-SHIFT_DR with BYPASS selected.
        scan(1'b1, 5, 32'h1F, dout, oe_bad);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        p0 = pulse_cnt;
        repeat (5) tick(1'b1, 1'b0);
        check("tms5_state", tap_state, 4'hF);
        check("tms5_ir", ir_value, 5'h01);
        check("tms5_npulse", pulse_cnt - p0, 0);

        // TRST low mid-SHIFT_IR.
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("sir_state", tap_state, 4'hA);
        check("sir_oe", jtag_tdo_oe, 1'b1);
        trst_n = 1'b0;
        clks(SYNC + 1);
        check("trst_state", tap_state, 4'hF);
        check("trst_oe", jtag_tdo_oe, 1'b0);
        trst_n = 1'b1;
        clks(4);

        // reset lands on the exact clk that would launch the update pulse.
        tick(1'b0, 1'b0);
        scan(1'b1, 5, 32'h02, dout, oe_bad);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        check("pre_upd_state", tap_state, 4'h1);
        p0 = pulse_cnt;
        tms = 1'b1;
        tck = 1'b1;
        clks(SYNC);
        reset = 1'b1;
        clks(3);
        tck = 1'b0;
        clks(3);
        reset = 1'b0;
        clks(4);
        check("rstupd_npulse", pulse_cnt - p0, 0);
        check("rstupd_state", tap_state, 4'hF);
        check("rstupd_data", upd_data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
